// File: rtl/popcnt_rr_scheduler_if.sv
// Bundle of client-side request/response and datapath-side handshake signals
// shared by the round-robin bit-count scheduler and its surroundings.
interface popcnt_rr_scheduler_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic           resp_err;
    logic           busy;
    logic           dp_start;
    logic [W-1:0]   dp_in_data;
    logic [W-1:0]   dp_result;
    logic           dp_ready;

    // master: the scheduler itself
    modport master (
        input  req, req_data, dp_result, dp_ready,
        output grant, resp_valid, resp_data, resp_err, busy, dp_start, dp_in_data
    );

    // slave: clients plus the datapath seen as one environment
    modport slave (
        output req, req_data, dp_result, dp_ready,
        input  grant, resp_valid, resp_data, resp_err, busy, dp_start, dp_in_data
    );
endinterface

// File: rtl/popcnt_rr_scheduler.sv
// Round-robin scheduler sharing one sequential bit-count datapath among N
// requesters, with a timeout guard on every datapath operation.
module popcnt_rr_scheduler #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    popcnt_rr_scheduler_if.master  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ACK, RUN, RESP} state_t;

    state_t         state_reg;
    logic [PW-1:0]  ptr_reg;
    logic [PW-1:0]  owner_reg;
    logic [TW-1:0]  timer_reg;
    logic [N-1:0]   grant_reg;
    logic [N-1:0]   resp_valid_reg;
    logic [W-1:0]   resp_data_reg;
    logic           resp_err_reg;
    logic           busy_reg;
    logic           dp_start_reg;
    logic [W-1:0]   dp_in_data_reg;

    logic [W-1:0]   operand [N];
    logic [PW-1:0]  winner;
    logic           found;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_operand
            assign operand[gi] = bus.req_data[gi*W +: W];
        end
    endgenerate

    // First requester found searching upward from the one after the last served.
    always_comb begin
        winner = ptr_reg;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && bus.req[(int'(ptr_reg) + k) % N]) begin
                winner = PW'((int'(ptr_reg) + k) % N);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= PW'(N - 1);
            owner_reg      <= '0;
            timer_reg      <= '0;
            grant_reg      <= '0;
            resp_valid_reg <= '0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            dp_start_reg   <= 1'b0;
            dp_in_data_reg <= '0;
        end else begin
            grant_reg      <= '0;
            resp_valid_reg <= '0;
            dp_start_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|bus.req) begin
                        grant_reg      <= {{(N-1){1'b0}}, 1'b1} << winner;
                        dp_in_data_reg <= operand[winner];
                        owner_reg      <= winner;
                        ptr_reg        <= winner;
                        busy_reg       <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    dp_start_reg <= 1'b1;
                    timer_reg    <= '0;
                    state_reg    <= ACK;
                end
                ACK: begin
                    // Ready dropping low proves the datapath accepted the start.
                    if (!bus.dp_ready) begin
                        timer_reg <= timer_reg + 1'b1;
                        state_reg <= RUN;
                    end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                        resp_data_reg  <= '0;
                        resp_err_reg   <= 1'b1;
                        resp_valid_reg <= {{(N-1){1'b0}}, 1'b1} << owner_reg;
                        state_reg      <= RESP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.dp_ready) begin
                        resp_data_reg  <= bus.dp_result;
                        resp_err_reg   <= 1'b0;
                        resp_valid_reg <= {{(N-1){1'b0}}, 1'b1} << owner_reg;
                        state_reg      <= RESP;
                    end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                        resp_data_reg  <= '0;
                        resp_err_reg   <= 1'b1;
                        resp_valid_reg <= {{(N-1){1'b0}}, 1'b1} << owner_reg;
                        state_reg      <= RESP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                RESP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.busy       = busy_reg;
    assign bus.dp_start   = dp_start_reg;
    assign bus.dp_in_data = dp_in_data_reg;
endmodule
